// File: rtl/readout_byte_framer_if.sv
// Bus between the flag inserter / 8b10b encoder side (master) and the byte framer (slave).
// Word side: word_write is a one-cycle strobe accepted when full=0; byte side: one byte_req pulse per slot.
interface readout_byte_framer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [23:0]         word_in;
    logic                word_write;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                byte_req;
    logic [7:0]          byte_out;
    logic                byte_k;
    logic                in_frame;

    modport master (
        output word_in, word_write, byte_req,
        input  full, count, overflow, byte_out, byte_k, in_frame
    );

    modport slave (
        input  word_in, word_write, byte_req,
        output full, count, overflow, byte_out, byte_k, in_frame
    );
endinterface

// File: rtl/readout_byte_framer.sv
// Buffers 24-bit readout words and serialises them MSB-first into SOF/EOF-wrapped byte frames,
// emitting the idle K-character whenever no frame is open.
module readout_byte_framer #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] IDLE_K     = 8'h3C,
    parameter logic [7:0] SOF_K      = 8'hFC,
    parameter logic [7:0] EOF_K      = 8'hBC
) (
    input  logic                   clk,
    input  logic                   reset,
    readout_byte_framer_if.slave   bus,
    output logic [2:0]             state_dbg
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B2   = 3'd1;
    localparam logic [2:0] S_B1   = 3'd2;
    localparam logic [2:0] S_B0   = 3'd3;
    localparam logic [2:0] S_EOF  = 3'd4;

    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [23:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic [2:0]            state;
    logic [7:0]            byte_q;
    logic                  byte_k_q;
    logic                  in_frame_q;

    logic        full;
    logic        wr_acc;
    logic        pop;
    logic        more_after_pop;
    logic [23:0] head;

    // Occupancy never exceeds the depth, so the top count bit alone marks full.
    assign full           = count_q[DEPTH_LOG2];
    assign wr_acc         = bus.word_write && !full;
    assign pop            = bus.byte_req && (state == S_B0);
    assign more_after_pop = (count_q != CNT_ONE) || wr_acc;
    assign head           = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (bus.word_write && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Framer only moves on byte_req; outputs hold between requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_q     <= IDLE_K;
            byte_k_q   <= 1'b1;
            in_frame_q <= 1'b0;
        end else if (bus.byte_req) begin
            case (state)
                S_IDLE: begin
                    if (count_q != '0) begin
                        byte_q     <= SOF_K;
                        byte_k_q   <= 1'b1;
                        in_frame_q <= 1'b1;
                        state      <= S_B2;
                    end else begin
                        byte_q   <= IDLE_K;
                        byte_k_q <= 1'b1;
                    end
                end
                S_B2: begin
                    byte_q   <= head[23:16];
                    byte_k_q <= 1'b0;
                    state    <= S_B1;
                end
                S_B1: begin
                    byte_q   <= head[15:8];
                    byte_k_q <= 1'b0;
                    state    <= S_B0;
                end
                S_B0: begin
                    byte_q   <= head[7:0];
                    byte_k_q <= 1'b0;
                    state    <= more_after_pop ? S_B2 : S_EOF;
                end
                S_EOF: begin
                    byte_q     <= EOF_K;
                    byte_k_q   <= 1'b1;
                    in_frame_q <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    byte_q     <= IDLE_K;
                    byte_k_q   <= 1'b1;
                    in_frame_q <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.byte_out = byte_q;
    assign bus.byte_k   = byte_k_q;
    assign bus.in_frame = in_frame_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_readout_byte_framer.sv
// Directed bench for readout_byte_framer: expected {k, byte} pairs are queued as words are
// written and popped as each byte_req slot is consumed.
module tb_readout_byte_framer;
    localparam int DEPTH_LOG2 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state_dbg;
    int         total = 0;
    int         bad   = 0;
    logic [8:0] exp_q[$];

    readout_byte_framer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    readout_byte_framer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_k(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
    endtask

    task automatic push_word(input logic [23:0] w);
        exp_q.push_back({1'b0, w[23:16]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b0, w[7:0]});
    endtask

    task automatic write_word(input logic [23:0] w);
        bus.word_in    = w;
        bus.word_write = 1'b1;
        tick();
        bus.word_write = 1'b0;
    endtask

    // One byte slot, optionally with a same-edge write; the loaded byte is checked against the queue.
    task automatic req(input string tag, input logic with_write, input logic [23:0] w);
        logic [8:0] e;
        bus.byte_req   = 1'b1;
        bus.word_write = with_write;
        bus.word_in    = w;
        tick();
        bus.byte_req   = 1'b0;
        bus.word_write = 1'b0;
        chk({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, {23'd0, bus.byte_k, bus.byte_out}, {23'd0, e});
        end
    endtask

    logic [23:0] ovf_words [17];

    initial begin
        reset          = 1'b1;
        bus.word_in    = '0;
        bus.word_write = 1'b0;
        bus.byte_req   = 1'b0;

        // Reset dominates requests and writes in the same cycle.
        tick();
        bus.byte_req   = 1'b1;
        bus.word_write = 1'b1;
        bus.word_in    = 24'h123456;
        tick();
        bus.byte_req   = 1'b0;
        bus.word_write = 1'b0;
        chk("rst_byte", {23'd0, bus.byte_k, bus.byte_out}, 32'h13C);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_k(8'h3C);
            req("idle_byte", 1'b0, 24'h0);
            chk("idle_inframe", 32'(bus.in_frame), 32'd0);
            chk("idle_count", 32'(bus.count), 32'd0);
            chk("idle_ovf", 32'(bus.overflow), 32'd0);
            chk("idle_full", 32'(bus.full), 32'd0);
        end

        // Single word
        push_k(8'hFC);
        write_word(24'hE91234);
        push_word(24'hE91234);
        push_k(8'hBC);
        push_k(8'h3C);
        chk("single_count_wr", 32'(bus.count), 32'd1);
        req("single_sof", 1'b0, 24'h0);
        chk("single_inframe_sof", 32'(bus.in_frame), 32'd1);
        req("single_b2", 1'b0, 24'h0);
        req("single_b1", 1'b0, 24'h0);
        chk("single_count_b1", 32'(bus.count), 32'd1);
        req("single_b0", 1'b0, 24'h0);
        chk("single_count_b0", 32'(bus.count), 32'd0);
        chk("single_inframe_b0", 32'(bus.in_frame), 32'd1);
        req("single_eof", 1'b0, 24'h0);
        chk("single_inframe_eof", 32'(bus.in_frame), 32'd0);
        req("single_idle", 1'b0, 24'h0);

        // Back-to-back words share one frame
        push_k(8'hFC);
        write_word(24'hE90001);
        push_word(24'hE90001);
        write_word(24'h123456);
        push_word(24'h123456);
        push_k(8'hBC);
        chk("b2b_count", 32'(bus.count), 32'd2);
        for (int i = 0; i < 8; i++) req("b2b_byte", 1'b0, 24'h0);
        chk("b2b_state", 32'(state_dbg), 32'd0);

        // Late append on the B0 edge keeps the frame open
        push_k(8'hFC);
        write_word(24'hAAAAAA);
        push_word(24'hAAAAAA);
        req("late_sof", 1'b0, 24'h0);
        req("late_b2", 1'b0, 24'h0);
        req("late_b1", 1'b0, 24'h0);
        push_word(24'h555555);
        push_k(8'hBC);
        req("late_b0", 1'b1, 24'h555555);
        chk("late_count", 32'(bus.count), 32'd1);
        chk("late_state", 32'(state_dbg), 32'd1);
        for (int i = 0; i < 4; i++) req("late_byte", 1'b0, 24'h0);
        chk("late_inframe", 32'(bus.in_frame), 32'd0);

        // Overflow: 17 writes into a 16-deep FIFO
        push_k(8'hFC);
        for (int i = 0; i < 17; i++) begin
            ovf_words[i] = 24'($urandom_range(0, 24'hFFFFFF));
            write_word(ovf_words[i]);
            if (i < 16) push_word(ovf_words[i]);
            if (i == 15) begin
                chk("ovf_full16", 32'(bus.full), 32'd1);
                chk("ovf_ovf16", 32'(bus.overflow), 32'd0);
            end
        end
        push_k(8'hBC);
        push_k(8'h3C);
        chk("ovf_count", 32'(bus.count), 32'd16);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 51; i++) req("ovf_byte", 1'b0, 24'h0);
        chk("ovf_count_end", 32'(bus.count), 32'd0);
        chk("ovf_still_set", 32'(bus.overflow), 32'd1);
        chk("ovf_full_end", 32'(bus.full), 32'd0);

        // Reset mid-frame discards everything
        push_k(8'hFC);
        write_word(24'h0F1E2D);
        exp_q.push_back({1'b0, 8'h0F});
        write_word(24'h3C4B5A);
        req("mid_sof", 1'b0, 24'h0);
        req("mid_b2", 1'b0, 24'h0);
        chk("mid_state_b1", 32'(state_dbg), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_count", 32'(bus.count), 32'd0);
        chk("mid_ovf_clr", 32'(bus.overflow), 32'd0);
        chk("mid_inframe", 32'(bus.in_frame), 32'd0);
        push_k(8'h3C);
        push_k(8'h3C);
        req("mid_idle0", 1'b0, 24'h0);
        req("mid_idle1", 1'b0, 24'h0);

        // Clean restart after the mid-frame reset
        push_k(8'hFC);
        write_word(24'hC0FFEE);
        push_word(24'hC0FFEE);
        push_k(8'hBC);
        push_k(8'h3C);
        for (int i = 0; i < 6; i++) req("restart_byte", 1'b0, 24'h0);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
